muldiv_unit: RTL and testbench

- Iterative multiply/divide unit for the RV32M instructions in the execute stage.
- Consumes the same forwarded SrcA/SrcB operands as the ALU.
- Holds the pipeline via `busy` and presents a registered result, which the execute-stage result mux selects instead of ALUResult.
- Fixed-latency, one operation in flight, shift-add multiply and restoring divide, one bit per cycle.

---
 rtl/muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_muldiv_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle.
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiplies and divide corner cases finish one edge after Start.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  Start,
  input  logic                  Flush,
  input  logic [OP_WIDTH-1:0]   Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [OP_WIDTH-1:0] op;
  logic [W-1:0]        hi, lo, src;
  logic [CW-1:0]       cnt;
  logic                neg_q, neg_r, div_zero, ovf;

  // operand decode at Start
  logic         is_div, a_sgn, b_sgn, a_neg, b_neg, dz_in, ov_in, accept;
  logic [W-1:0] a_mag, b_mag;

  always_comb begin
    is_div = Operation[2];
    a_sgn  = is_div ? ~Operation[0] : (Operation[1:0] != 2'b11);
    b_sgn  = is_div ? ~Operation[0] : ~Operation[1];
    a_neg  = a_sgn & SrcA[W-1];
    b_neg  = b_sgn & SrcB[W-1];
    a_mag  = a_neg ? -SrcA : SrcA;
    b_mag  = b_neg ? -SrcB : SrcB;
    dz_in  = (SrcB == '0);
    ov_in  = b_sgn & (SrcA == MIN_NEG) & (&SrcB);
    accept = Start & (state != CALC) & ~Flush;
  end

  // one iteration: hi/lo form the product (multiply) or remainder/quotient (divide)
  logic [W:0]     sum, shifted, diff;
  logic           ge;
  logic [W-1:0]   nxt_hi, nxt_lo, quo, rem, fin_res;
  logic [2*W-1:0] prod;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, src} : '0);
    shifted = {hi, lo[W-1]};
    diff    = shifted - {1'b0, src};
    ge      = ~diff[W];
    if (op[2]) begin
      nxt_hi = ge ? diff[W-1:0] : shifted[W-1:0];
      nxt_lo = {lo[W-2:0], ge};
    end else begin
      nxt_hi = sum[W:1];
      nxt_lo = {sum[0], lo[W-1:1]};
    end
    prod = {nxt_hi, nxt_lo};
    if (neg_q) prod = -prod;
    quo = neg_q ? -nxt_lo : nxt_lo;
    rem = neg_r ? -nxt_hi : nxt_hi;
    if (!op[2])
      fin_res = (op[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
    else if (op[1])
      fin_res = ovf ? '0 : (div_zero ? rem : rem);
    else
      fin_res = div_zero ? '1 : (ovf ? MIN_NEG : quo);
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic         early;
  logic [W-1:0] early_res;
  always_comb begin
    early     = is_div ? (dz_in | ov_in) : ((SrcA == '0) | (SrcB == '0));
    early_res = '0;
    if (is_div) begin
      if (Operation[1]) early_res = dz_in ? SrcA : '0;
      else              early_res = dz_in ? '1 : MIN_NEG;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Result   <= '0;
      op       <= '0;
      hi       <= '0;
      lo       <= '0;
      src      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else if (Flush) begin
      state <= IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else if (accept) begin
      op       <= Operation;
      hi       <= '0;
      lo       <= is_div ? a_mag : b_mag;
      src      <= is_div ? b_mag : a_mag;
      cnt      <= CW'(W - 1);
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      div_zero <= dz_in;
      ovf      <= ov_in;
`ifdef MULDIV_EARLY_OUT_EN
      if (early) begin
        state  <= DONE;
        Busy   <= 1'b0;
        Done   <= 1'b1;
        Result <= early_res;
      end else begin
        state <= CALC;
        Busy  <= 1'b1;
        Done  <= 1'b0;
      end
`else
      state <= CALC;
      Busy  <= 1'b1;
      Done  <= 1'b0;
`endif
    end else begin
      case (state)
        CALC: begin
          hi  <= nxt_hi;
          lo  <= nxt_lo;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state  <= DONE;
            Busy   <= 1'b0;
            Done   <= 1'b1;
            Result <= fin_res;
          end
        end
        DONE: begin
          state <= IDLE;
          Done  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized + directed bench for muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0, reset_n = 1'b0, Start = 1'b0, Flush = 1'b0;
  logic [2:0]   Operation = '0;
  logic [W-1:0] SrcA = '0, SrcB = '0;
  logic         Busy, Done;
  logic [W-1:0] Result;

  int           n_chk = 0, n_pass = 0;
  logic [W-1:0] last_exp = '0;

  muldiv_unit #(.DATA_WIDTH(W), .OP_WIDTH(3)) dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .Flush(Flush),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB),
    .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    logic ov;
    sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
    ua = {32'b0, a};       ub = {32'b0, b};
    ia = a; ib = b;
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p  = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ov ? 32'h8000_0000 : W'(ia / ib));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ov ? 32'h0 : W'(ia % ib));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 0;
    if (!op[2] && (a == 0 || b == 0)) return 0;
`endif
    return 32;
  endfunction

  // Done is counted in edges after the accepting edge; poke>0 re-asserts Start mid-CALC
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
    int cyc, lat;
    logic [W-1:0] exp;
    exp = model(op, a, b);
    lat = exp_lat(op, a, b);
    @(negedge clk);
    Start = 1'b1; Operation = op; SrcA = a; SrcB = b;
    @(posedge clk); @(negedge clk);
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom; Operation = 3'($urandom);
    chk("busy_after_start", Busy, 64'(lat != 0));
    cyc = 0;
    while (!Done && cyc < 100) begin
      Start = (poke > 0 && cyc == poke);
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    Start = 1'b0;
    chk("latency", cyc, lat);
    chk($sformatf("result op%0d %h,%h", op, a, b), Result, exp);
    chk("busy_in_done", Busy, 0);
    last_exp = exp;
    @(posedge clk); @(negedge clk);
    chk("done_single_pulse", Done, 0);
  endtask

  logic [2:0]   d_op [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [W-1:0] d_a  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100,
                              32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'h5555_1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
  logic [W-1:0] d_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd7,
                              32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    int t1, t2, cyc;
    logic seen;
    logic [W-1:0] ra, rb;
    logic [2:0] rop;

    repeat (3) @(negedge clk);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_result", Result, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_result", Result, 0);

    for (int i = 0; i < 12; i++) run_op(d_op[i], d_a[i], d_b[i], 0);

    // Start during CALC must be ignored
    run_op(3'd5, 32'd100, 32'd7, 5);

    // Flush mid-DIVU: no Done, Result keeps prior value
    @(negedge clk);
    Start = 1'b1; Operation = 3'd5; SrcA = 32'd1000; SrcB = 32'd3;
    @(negedge clk); Start = 1'b0;
    repeat (9) @(negedge clk);
    Flush = 1'b1;
    @(negedge clk); Flush = 1'b0;
    chk("flush_busy", Busy, 0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (Done) seen = 1'b1; end
    chk("flush_no_done", seen, 0);
    chk("flush_result_held", Result, last_exp);

    // Flush beats Start
    Flush = 1'b1; Start = 1'b1; Operation = 3'd0; SrcA = 32'd3; SrcB = 32'd3;
    @(negedge clk); Flush = 1'b0; Start = 1'b0;
    chk("flush_over_start", Busy, 0);

    // back-to-back with Start held through DONE
    Start = 1'b1; Operation = 3'd3; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF;
    @(negedge clk);
    Operation = 3'd5; SrcA = 32'd100; SrcB = 32'd7;
    cyc = 0; t1 = -1; t2 = -1;
    while (cyc < 120 && t2 < 0) begin
      if (Done) begin
        if (t1 < 0) begin
          t1 = cyc;
          chk("b2b_result1", Result, 32'hFFFF_FFFE);
        end else t2 = cyc;
      end
      if (t1 >= 0 && cyc == t1 + 1) begin
        Start = 1'b0;
        chk("b2b_no_idle", Busy, 1);
      end
      if (t2 < 0) begin @(negedge clk); cyc++; end
    end
    Start = 1'b0;
    chk("b2b_spacing", t2 - t1, 33);
    chk("b2b_result2", Result, 32'd14);
    last_exp = 32'd14;
    @(negedge clk);

    // asynchronous reset mid-CALC
    @(negedge clk);
    Start = 1'b1; Operation = 3'd0; SrcA = 32'd9; SrcB = 32'd9;
    @(negedge clk); Start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_busy", Busy, 0);
    chk("areset_done", Done, 0);
    chk("areset_result", Result, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (Done) seen = 1'b1; end
    chk("areset_no_done", seen, 0);
    chk("areset_result_after", Result, 0);

    // randomized ops with corner injection
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = '0;
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: rb = 32'($urandom_range(1, 300));
        default: ;
      endcase
      run_op(rop, ra, rb, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
